sdp_ram_player: RTL and testbench
=================================

Name: sdp_ram_player

Overview:
- Read-side sequencer for the simple-dual-port RAM filled by the AXI write interface.
- On a start command, reads a contiguous run of RAM words and streams them out as an AXI4-Stream master, one word per beat.
- Tracks fixed RAM read latency with a credit scheme and an output FIFO, so TREADY backpressure never loses a word and sustained throughput is one beat/clk.
- Sits between the RAM read port and downstream stream consumers (DMA packetiser, loopback test logic).

Parameters:
- DW, 512, data width of RAM word and stream beat
- AW, 10, RAM word-address width
- CW, 16, width of beat_count
- RL, 2, RAM read latency in clocks (ram_re cycle to ram_rdata valid); legal 1..4
- FD, 4, output FIFO depth in words; must be >= RL+2, power of two

Ports:
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- start  in  1  command strobe, sampled only when idle
- start_addr  in  AW  first RAM word address
- beat_count  in  CW  number of words to stream
- abort  in  1  cancel current run
- busy  out  1  high from accepted start until done/abort completes
- done  out  1  one-clk pulse after last beat handshakes
- ram_raddr  out  AW  RAM read address (registered)
- ram_re  out  1  RAM read enable (registered)
- ram_rdata  in  DW  RAM read data, valid RL clks after ram_re
- axis_tdata  out  DW  stream data
- axis_tvalid  out  1  stream valid
- axis_tlast  out  1  high on final beat of run
- axis_tready  in  1  stream ready

Behaviour:
- Reset values: busy=0, done=0, ram_re=0, ram_raddr=0, axis_tvalid=0, axis_tlast=0. FIFO is emptied, credits cleared, in-flight pipe cleared.
- FSM states: IDLE, ISSUE, DRAIN, FLUSH.
- IDLE:
  - start=1 with beat_count>0: latch start_addr and beat_count, busy<=1, go to ISSUE.
  - start=1 with beat_count=0: done pulses the next clk, busy stays 0, no reads are issued.
- ISSUE:
  - Each clk with outstanding (in-flight reads + FIFO occupancy) < FD and remaining issue count > 0: ram_re<=1, ram_raddr<=current address, address+1, remaining issue count-1.
  - Address wraps modulo 2^AW (0x3FF -> 0x000 at AW=10).
  - When the last read is issued, go to DRAIN.
- Latency: start accepted at clk S -> first ram_re at S+1 -> rdata captured at S+1+RL -> axis_tvalid first high at S+RL+2 (S+4 at default).
- Read-return tracking: a shift-register valid pipe of depth RL marks returning words. Each returning word is written into the FIFO unconditionally. The credit check guarantees the FIFO never overflows.
- Stream output:
  - axis_tvalid = FIFO non-empty; axis_tdata = FIFO head.
  - Beat consumed when axis_tvalid & axis_tready.
  - A simultaneous FIFO write and read in one clk is legal; occupancy is unchanged.
  - Once tvalid is asserted, tdata must stay stable until the handshake.
  - axis_tlast=1 only on the beat whose index equals beat_count-1, counted by a separate delivered-beat counter.
- DRAIN: when the tlast beat handshakes, done<=1 for one clk, busy<=0, go to IDLE. The next start is accepted no earlier than the clk after done.
- start is ignored while busy=1; latched command fields are unaffected.
- abort:
  - In ISSUE or DRAIN: stop issuing immediately, drop axis_tvalid, discard FIFO contents, go to FLUSH.
  - FLUSH: returning reads are discarded; when the valid pipe is empty, busy<=0 and go to IDLE. done is not pulsed.
  - abort in IDLE has no effect.
  - abort and the tlast handshake in the same clk: abort wins, no done.
- resetn=0 mid-run: all state is dropped, and no stale RAM data appears on the stream after reset.
- beat_count = 2^CW-1 is legal; internal counters are CW bits.

Test Plan:
- RAM preloaded word[i]=i; start_addr=0x010, beat_count=8, tready=1 -> 8 beats of data 0x10..0x17; first tvalid at S+4; tlast only on 0x17; done one clk after the last handshake; busy high S+1 through the done clk.
- Same run with tready toggling 1-0-0-1 pseudo-randomly -> identical ordered data, no duplicates or drops, FIFO occupancy never exceeds FD, ram_re stalls once outstanding=FD.
- start_addr=0x3FD, beat_count=5 -> data 0x3FD, 0x3FE, 0x3FF, 0x000, 0x001; tlast on 0x001.
- beat_count=0 -> no ram_re, no tvalid, done pulse the clk after start, busy stays 0. Then start with beat_count=1 -> single beat with tlast=1.
- beat_count=64, abort asserted after 10 handshakes with tready=1 -> tvalid drops the next clk, no done, busy falls after at most RL+1 clks. Follow-up run of 4 beats from 0x000 -> exactly data 0..3, no leftover words.
- start pulsed again mid-run with different fields -> ignored, the original run completes unchanged. resetn low for 1 clk mid-run -> all outputs at reset values, no tvalid until a new start.

Source files
------------

// File: rtl/sdp_ram_player_if.sv
// sdp_ram_player_if: command, RAM read port and AXI4-Stream signals of the RAM player
interface sdp_ram_player_if #(
  parameter int DW = 512,
  parameter int AW = 10,
  parameter int CW = 16
);
  logic          start;
  logic [AW-1:0] start_addr;
  logic [CW-1:0] beat_count;
  logic          abort;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_raddr;
  logic          ram_re;
  logic [DW-1:0] ram_rdata;
  logic [DW-1:0] axis_tdata;
  logic          axis_tvalid;
  logic          axis_tlast;
  logic          axis_tready;
  modport slave (
    input  start, start_addr, beat_count, abort, ram_rdata, axis_tready,
    output busy, done, ram_raddr, ram_re, axis_tdata, axis_tvalid, axis_tlast
  );
  modport master (
    output start, start_addr, beat_count, abort, ram_rdata, axis_tready,
    input  busy, done, ram_raddr, ram_re, axis_tdata, axis_tvalid, axis_tlast
  );
endinterface

// File: rtl/sdp_ram_player.sv
// sdp_ram_player: streams a contiguous run of RAM words out as AXI4-Stream with credit-based flow control
module sdp_ram_player #(
  parameter int DW = 512,
  parameter int AW = 10,
  parameter int CW = 16,
  parameter int RL = 2,
  parameter int FD = 4
) (
  input logic clk,
  input logic resetn,
  sdp_ram_player_if.slave bus
);
  localparam int PW = $clog2(FD);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FLUSH} state_t;
  state_t        r_state;
  logic          r_busy, r_done, r_re;
  logic [AW-1:0] r_raddr, r_addr;
  logic [CW-1:0] r_rem, r_len, r_beat;
  logic [RL-1:0] r_vpipe;
  logic [DW-1:0] r_mem [FD];
  logic [PW-1:0] r_wp, r_rp;
  logic [PW:0]   r_cnt;
  logic          w_run, w_abort, w_pop, w_wr, w_issue, w_last;
  logic [7:0]    w_outst;
  logic [RL-1:0] w_pipe_nx;
  assign w_run     = r_state == ISSUE || r_state == DRAIN;
  assign w_abort   = w_run && bus.abort;
  assign w_pop     = r_cnt != '0 && bus.axis_tready;
  assign w_wr      = w_run && !bus.abort && r_vpipe[RL-1];
  assign w_last    = r_beat == r_len - CW'(1);
  assign w_issue   = r_state == ISSUE && !bus.abort && w_outst < 8'(FD);
  assign w_pipe_nx = RL'({r_vpipe, r_re});
  // words owed to the FIFO: occupancy plus every read still in flight, less the beat leaving now
  always_comb begin
    w_outst = 8'(r_cnt) + 8'(r_re) - 8'(w_pop);
    for (int i = 0; i < RL; i++) w_outst = w_outst + 8'(r_vpipe[i]);
  end
  // valid marker follows each read through the fixed RAM latency
  always_ff @(posedge clk)
    if (!resetn) r_vpipe <= '0;
    else r_vpipe <= w_pipe_nx;
  // FIFO pointers and occupancy; abort throws away everything held
  always_ff @(posedge clk)
    if (!resetn || w_abort) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= w_wr ? r_wp + PW'(1) : r_wp;
      r_rp  <= w_pop ? r_rp + PW'(1) : r_rp;
      r_cnt <= r_cnt + (PW+1)'(w_wr) - (PW+1)'(w_pop);
    end
  // FIFO storage; returning words land here unconditionally while a run is live
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wp] <= bus.ram_rdata;
  // control FSM: command capture, read issue, beat counting and completion
  always_ff @(posedge clk)
    if (!resetn) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_re    <= 1'b0;
      r_raddr <= '0;
      r_addr  <= '0;
      r_rem   <= '0;
      r_len   <= '0;
      r_beat  <= '0;
    end else begin
      r_done  <= 1'b0;
      r_re    <= w_issue;
      r_raddr <= w_issue ? r_addr : r_raddr;
      r_addr  <= w_issue ? r_addr + AW'(1) : r_addr;
      r_rem   <= w_issue ? r_rem - CW'(1) : r_rem;
      r_beat  <= w_pop ? r_beat + CW'(1) : r_beat;
      case (r_state)
        IDLE:
          if (bus.start && bus.beat_count == '0) r_done <= 1'b1;
          else if (bus.start) begin
            r_addr  <= bus.start_addr;
            r_rem   <= bus.beat_count;
            r_len   <= bus.beat_count;
            r_beat  <= '0;
            r_busy  <= 1'b1;
            r_state <= ISSUE;
          end
        ISSUE:
          if (bus.abort) r_state <= FLUSH;
          else if (w_issue && r_rem == CW'(1)) r_state <= DRAIN;
        DRAIN:
          if (bus.abort) r_state <= FLUSH;
          else if (w_pop && w_last) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        FLUSH:
          if (w_pipe_nx == '0) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        default: r_state <= IDLE;
      endcase
    end
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.ram_re      = r_re;
  assign bus.ram_raddr   = r_raddr;
  assign bus.axis_tvalid = r_cnt != '0;
  assign bus.axis_tdata  = r_mem[r_rp];
  assign bus.axis_tlast  = r_cnt != '0 && w_last;
endmodule

// File: tb/tb_sdp_ram_player.sv
// tb_sdp_ram_player: directed vector bench for sdp_ram_player with a 2-clk-latency RAM model
module tb_sdp_ram_player;
  localparam int DW = 512;
  localparam int AW = 10;
  localparam int CW = 16;
  localparam int RL = 2;
  localparam int FD = 4;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int total = 0;
  int bad = 0;
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] q1, q2;
  sdp_ram_player_if #(.DW(DW), .AW(AW), .CW(CW)) bus();
  sdp_ram_player #(.DW(DW), .AW(AW), .CW(CW), .RL(RL), .FD(FD)) dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  // RAM: read data appears RL clocks after the cycle ram_re/ram_raddr are presented
  always @(posedge clk) begin
    q1 <= mem[bus.ram_raddr];
    q2 <= q1;
  end
  assign bus.ram_rdata = q2;
  typedef struct {
    logic [AW-1:0] addr;
    int            n;
    int            mode;
    logic [AW-1:0] last;
    string         nm;
  } vec_t;
  vec_t vt[5];
  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  // mode 0: tready=1, mode 1: random tready, mode 3: extra start pulse mid-run
  task automatic run_cmd(input logic [AW-1:0] a, input int n, input int mode, input logic [AW-1:0] exp_last, input string nm);
    int got = 0, iss = 0, maxo = 0, first = -1, last_k = -1, done_k = -1;
    int addr_bad = 0, busy_bad = 0;
    logic [AW-1:0] ea;
    @(negedge clk);
    bus.start = 1'b1;
    bus.start_addr = a;
    bus.beat_count = CW'(n);
    @(negedge clk);
    bus.start = 1'b0;
    chk({nm, " busy_after_start"}, DW'(bus.busy), DW'(1));
    for (int k = 0; k < 400 && done_k < 0; k++) begin
      if (k > 0) @(negedge clk);
      bus.start = mode == 3 && k == 3;
      if (mode == 3) begin
        bus.start_addr = 10'h200;
        bus.beat_count = 16'd2;
      end
      bus.axis_tready = mode == 1 ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.ram_re) begin
        ea = a + AW'(iss);
        if (bus.ram_raddr !== ea) addr_bad++;
        iss++;
      end
      if (iss - got > maxo) maxo = iss - got;
      if (bus.done) done_k = k;
      else if (!bus.busy) busy_bad++;
      if (bus.axis_tvalid && first < 0) first = k;
      if (bus.axis_tvalid && bus.axis_tready && done_k < 0) begin
        ea = a + AW'(got);
        chk({nm, " data"}, bus.axis_tdata, DW'(ea));
        chk({nm, " tlast"}, DW'(bus.axis_tlast), DW'(got == n - 1));
        if (got == n - 1) begin
          chk({nm, " last_data"}, bus.axis_tdata, DW'(exp_last));
          last_k = k;
        end
        got++;
      end
    end
    bus.start = 1'b0;
    chk({nm, " beats"}, DW'(got), DW'(n));
    chk({nm, " reads"}, DW'(iss), DW'(n));
    chk({nm, " raddr_seq_errors"}, DW'(addr_bad), DW'(0));
    chk({nm, " first_tvalid_k"}, DW'(first), DW'(4));
    chk({nm, " done_k"}, DW'(done_k), DW'(last_k + 1));
    chk({nm, " busy_at_done"}, DW'(bus.busy), DW'(0));
    chk({nm, " busy_drop_during_run"}, DW'(busy_bad), DW'(0));
    chk({nm, " outstanding_le_fd"}, DW'(maxo <= FD), DW'(1));
    @(negedge clk);
    chk({nm, " tvalid_after"}, DW'(bus.axis_tvalid), DW'(0));
    chk({nm, " done_one_pulse"}, DW'(bus.done), DW'(0));
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int hs, bk, cnt;
    for (int i = 0; i < 1024; i++) mem[i] = DW'(i);
    vt[0] = '{10'h010, 8, 0, 10'h017, "run8"};
    vt[1] = '{10'h010, 8, 1, 10'h017, "run8_bp"};
    vt[2] = '{10'h3FD, 5, 0, 10'h001, "wrap"};
    vt[3] = '{10'h000, 1, 0, 10'h000, "single"};
    vt[4] = '{10'h040, 6, 3, 10'h045, "restart_ignored"};
    bus.start = 1'b0;
    bus.start_addr = '0;
    bus.beat_count = '0;
    bus.abort = 1'b0;
    bus.axis_tready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst busy", DW'(bus.busy), DW'(0));
    chk("rst done", DW'(bus.done), DW'(0));
    chk("rst ram_re", DW'(bus.ram_re), DW'(0));
    chk("rst ram_raddr", DW'(bus.ram_raddr), DW'(0));
    chk("rst tvalid", DW'(bus.axis_tvalid), DW'(0));
    chk("rst tlast", DW'(bus.axis_tlast), DW'(0));
    resetn = 1'b1;
    for (int v = 0; v < 5; v++) run_cmd(vt[v].addr, vt[v].n, vt[v].mode, vt[v].last, vt[v].nm);
    @(negedge clk);
    bus.start = 1'b1;
    bus.beat_count = '0;
    @(negedge clk);
    bus.start = 1'b0;
    chk("zero done", DW'(bus.done), DW'(1));
    chk("zero busy", DW'(bus.busy), DW'(0));
    cnt = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (bus.ram_re || bus.axis_tvalid || bus.busy || bus.done) cnt++;
    end
    chk("zero quiet", DW'(cnt), DW'(0));
    run_cmd(10'h005, 1, 0, 10'h005, "single_after_zero");
    @(negedge clk);
    bus.start = 1'b1;
    bus.start_addr = 10'h080;
    bus.beat_count = 16'd64;
    @(negedge clk);
    bus.start = 1'b0;
    hs = 0;
    for (int k = 0; k < 200 && hs < 10; k++) begin
      if (k > 0) @(negedge clk);
      if (bus.axis_tvalid && bus.axis_tready) begin
        chk("abort data", bus.axis_tdata, DW'(10'h080 + AW'(hs)));
        hs++;
      end
    end
    chk("abort handshakes", DW'(hs), DW'(10));
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort tvalid", DW'(bus.axis_tvalid), DW'(0));
    bk = -1;
    cnt = 0;
    for (int j = 0; j <= RL; j++) begin
      if (bus.done) cnt++;
      if (!bus.busy) begin
        bk = j;
        break;
      end
      @(negedge clk);
    end
    chk("abort busy_falls", DW'(bk >= 0), DW'(1));
    chk("abort no_done", DW'(cnt), DW'(0));
    run_cmd(10'h000, 4, 0, 10'h003, "after_abort");
    @(negedge clk);
    bus.start = 1'b1;
    bus.start_addr = 10'h100;
    bus.beat_count = 16'd20;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("midrst busy", DW'(bus.busy), DW'(0));
    chk("midrst done", DW'(bus.done), DW'(0));
    chk("midrst ram_re", DW'(bus.ram_re), DW'(0));
    chk("midrst ram_raddr", DW'(bus.ram_raddr), DW'(0));
    chk("midrst tvalid", DW'(bus.axis_tvalid), DW'(0));
    chk("midrst tlast", DW'(bus.axis_tlast), DW'(0));
    cnt = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (bus.axis_tvalid || bus.ram_re || bus.busy) cnt++;
    end
    chk("midrst quiet", DW'(cnt), DW'(0));
    run_cmd(10'h020, 3, 0, 10'h022, "after_reset");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
